// File: rtl/alu_result_stage.sv
// Two-entry skid buffer holding ALU results (head + skid) with optional stored zero/negative flags.
// Define ALU_RESULT_STAGE_FLAGS_EN to generate the flags; otherwise zero_o/negative_o are tied low.
module alu_result_stage #(
    parameter int REGISTER_LENGTH = 64
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       flush_i,
    input  logic [REGISTER_LENGTH-1:0] result_i,
    input  logic                       valid_i,
    output logic                       ready_o,
    output logic [REGISTER_LENGTH-1:0] result_o,
    output logic                       zero_o,
    output logic                       negative_o,
    output logic                       valid_o,
    input  logic                       ready_i
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_HALF  = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0]                 state_q, state_d;
    logic [REGISTER_LENGTH-1:0] head_q, head_d;
    logic [REGISTER_LENGTH-1:0] skid_q, skid_d;
    logic                       accept, drain;
    logic                       head_ld_in, head_ld_skid, skid_ld;

    // Handshake outputs depend on registered state only.
    assign ready_o  = (state_q != ST_FULL);
    assign valid_o  = (state_q != ST_EMPTY);
    assign accept   = valid_i && ready_o;
    assign drain    = valid_o && ready_i;
    assign result_o = head_q;

    always_comb begin
        state_d      = state_q;
        head_ld_in   = 1'b0;
        head_ld_skid = 1'b0;
        skid_ld      = 1'b0;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    head_ld_in = 1'b1;
                    state_d    = ST_HALF;
                end
            end
            ST_HALF: begin
                if (accept && !drain) begin
                    skid_ld = 1'b1;
                    state_d = ST_FULL;
                end else if (!accept && drain) begin
                    state_d = ST_EMPTY;
                end else if (accept && drain) begin
                    head_ld_in = 1'b1;
                end
            end
            ST_FULL: begin
                if (drain) begin
                    head_ld_skid = 1'b1;
                    state_d      = ST_HALF;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        // Flush wins over any accept or drain in the same cycle.
        if (flush_i) begin
            state_d      = ST_EMPTY;
            head_ld_in   = 1'b0;
            head_ld_skid = 1'b0;
            skid_ld      = 1'b0;
        end
    end

    assign head_d = head_ld_in ? result_i : (head_ld_skid ? skid_q : head_q);
    assign skid_d = skid_ld ? result_i : skid_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_EMPTY;
            head_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
        end
    end

`ifdef ALU_RESULT_STAGE_FLAGS_EN
    // Flags are {negative, zero}, computed once at capture and carried with the entry.
    function automatic logic [1:0] calc_flags(input logic [REGISTER_LENGTH-1:0] v);
        return {v[REGISTER_LENGTH-1], (v == '0)};
    endfunction

    logic [1:0] head_flg_q, head_flg_d;
    logic [1:0] skid_flg_q, skid_flg_d;
    logic [1:0] in_flg;

    assign in_flg     = calc_flags(result_i);
    assign head_flg_d = head_ld_in ? in_flg : (head_ld_skid ? skid_flg_q : head_flg_q);
    assign skid_flg_d = skid_ld ? in_flg : skid_flg_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            head_flg_q <= 2'b00;
            skid_flg_q <= 2'b00;
        end else begin
            head_flg_q <= head_flg_d;
            skid_flg_q <= skid_flg_d;
        end
    end

    assign zero_o     = head_flg_q[0];
    assign negative_o = head_flg_q[1];
`else
    assign zero_o     = 1'b0;
    assign negative_o = 1'b0;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed self-checking bench for alu_result_stage; flag expectations follow ALU_RESULT_STAGE_FLAGS_EN.
module tb_alu_result_stage;

    localparam int W = 64;
`ifdef ALU_RESULT_STAGE_FLAGS_EN
    localparam bit FL = 1'b1;
`else
    localparam bit FL = 1'b0;
`endif

    logic         clk_i = 1'b0;
    logic         reset_i, flush_i, valid_i, ready_i;
    logic [W-1:0] result_i;
    logic         ready_o, zero_o, negative_o, valid_o;
    logic [W-1:0] result_o;

    int total  = 0;
    int passed = 0;

    alu_result_stage #(.REGISTER_LENGTH(W)) dut (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .flush_i    (flush_i),
        .result_i   (result_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .result_o   (result_o),
        .zero_o     (zero_o),
        .negative_o (negative_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    initial begin
        reset_i  = 1'b1;
        flush_i  = 1'b0;
        valid_i  = 1'b0;
        ready_i  = 1'b0;
        result_i = '0;
        tick();
        tick();
        reset_i = 1'b0;
        chk("rst_valid", valid_o, 0);
        chk("rst_ready", ready_o, 1);
        chk("rst_result", result_o, 0);
        chk("rst_zero", zero_o, 0);
        chk("rst_neg", negative_o, 0);

        // Single transfer
        result_i = 64'h00FF_00FF_00FF_00FF;
        valid_i  = 1'b1;
        ready_i  = 1'b1;
        tick();
        valid_i = 1'b0;
        chk("single_valid", valid_o, 1);
        chk("single_result", result_o, 64'h00FF_00FF_00FF_00FF);
        chk("single_zero", zero_o, 0);
        chk("single_neg", negative_o, 0);
        tick();
        chk("single_drained", valid_o, 0);

        // Backpressure
        ready_i  = 1'b0;
        valid_i  = 1'b1;
        result_i = 64'h0;
        tick();
        chk("bp_half_ready", ready_o, 1);
        chk("bp_half_result", result_o, 0);
        chk("bp_half_zero", zero_o, FL);
        result_i = 64'h8000_0000_0000_0000;
        tick();
        chk("bp_full_ready", ready_o, 0);
        chk("bp_full_valid", valid_o, 1);
        result_i = 64'h3333;
        tick();
        chk("bp_hold_ready", ready_o, 0);
        chk("bp_hold_result", result_o, 0);
        chk("bp_hold_zero", zero_o, FL);
        valid_i = 1'b0;
        ready_i = 1'b1;
        tick();
        chk("bp_second_valid", valid_o, 1);
        chk("bp_second_result", result_o, 64'h8000_0000_0000_0000);
        chk("bp_second_neg", negative_o, FL);
        chk("bp_second_zero", zero_o, 0);
        tick();
        chk("bp_empty", valid_o, 0);

        // Streaming: one accept and one drain per cycle, no bubbles
        valid_i = 1'b1;
        ready_i = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            result_i = W'(i);
            tick();
            chk("stream_valid", valid_o, 1);
            chk("stream_ready", ready_o, 1);
            chk("stream_result", result_o, W'(i));
        end
        valid_i = 1'b0;
        tick();
        chk("stream_end", valid_o, 0);

        // Flush while FULL, with a push in the same cycle
        ready_i  = 1'b0;
        valid_i  = 1'b1;
        result_i = 64'hA1;
        tick();
        result_i = 64'hA2;
        tick();
        chk("fl_full", ready_o, 0);
        flush_i  = 1'b1;
        result_i = 64'hDEAD;
        ready_i  = 1'b1;
        tick();
        flush_i = 1'b0;
        valid_i = 1'b0;
        chk("fl_valid", valid_o, 0);
        chk("fl_ready", ready_o, 1);
        tick();
        chk("fl_no_ghost", valid_o, 0);

        // Reset in FULL, with flush also asserted
        ready_i  = 1'b0;
        valid_i  = 1'b1;
        result_i = 64'h11;
        tick();
        result_i = 64'h8000_0000_0000_0022;
        tick();
        chk("mr_full", ready_o, 0);
        reset_i  = 1'b1;
        flush_i  = 1'b1;
        ready_i  = 1'b1;
        result_i = 64'h99;
        tick();
        reset_i = 1'b0;
        flush_i = 1'b0;
        ready_i = 1'b0;
        chk("mr_valid", valid_o, 0);
        chk("mr_ready", ready_o, 1);
        chk("mr_result", result_o, 0);
        chk("mr_zero", zero_o, 0);
        chk("mr_neg", negative_o, 0);
        result_i = 64'h5;
        tick();
        valid_i = 1'b0;
        chk("mr_push_valid", valid_o, 1);
        chk("mr_push_result", result_o, 64'h5);
        chk("mr_push_ready", ready_o, 1);
        ready_i = 1'b1;
        tick();
        chk("mr_alone", valid_o, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/alu_result_stage.md
ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 The block SHALL have parameter REGISTER_LENGTH, default 64, giving the datapath width in bits.
REQ-002 The block SHALL have clk_i, input, 1: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have reset_i, input, 1: synchronous, active-high reset.
REQ-004 The block SHALL have flush_i, input, 1: synchronous discard of all held entries.
REQ-005 The block SHALL have result_i, input, REGISTER_LENGTH: the ALU result from the upstream bitwise/arithmetic ops, for example the N-bit AND output.
REQ-006 The block SHALL have valid_i, input, 1: result_i is valid this cycle.
REQ-007 The block SHALL have ready_o, output, 1: the stage can accept result_i this cycle.
REQ-008 The block SHALL have result_o, output, REGISTER_LENGTH: the head entry's result, consumed by the downstream stage.
REQ-009 The block SHALL have zero_o, output, 1: the head entry's result equals 0.
REQ-010 The block SHALL have negative_o, output, 1: the head entry's result MSB.
REQ-011 The block SHALL have valid_o, output, 1: the head entry is valid.
REQ-012 The block SHALL have ready_i, input, 1: the downstream stage accepts the head entry this cycle.

Function
REQ-013 The block SHALL be a 2-entry skid buffer, made of a head register and a skid register, with states EMPTY (0 entries), HALF (1 entry) and FULL (2 entries).
REQ-014 The block SHALL count an accept when valid_i && ready_o, and a drain when valid_o && ready_i.
REQ-015 The block SHALL drive ready_o = (state != FULL) and valid_o = (state != EMPTY), decoded from registered state only, with no combinational path from ready_i or valid_i.
REQ-016 In EMPTY, an accept SHALL load the head register and move to HALF; result_o SHALL be visible the cycle after acceptance (latency 1).
REQ-017 In HALF, the block SHALL:
- on accept with no drain, load the skid register and move to FULL;
- on drain with no accept, move to EMPTY;
- on accept and drain together, load the head register with the new data and stay in HALF.
REQ-018 In FULL, a drain SHALL move the skid entry into the head register and go to HALF; with no drain, the state SHALL hold.
REQ-019 Entries SHALL leave in acceptance order; no entry SHALL be duplicated or lost except by flush or reset.
REQ-020 While valid_o=1 and ready_i=0, result_o, zero_o and negative_o SHALL remain stable.
REQ-021 The block SHALL compute the flags when an entry is captured and store them with that entry, not recompute them on the output path.
REQ-022 flush_i SHALL override accept and drain in the same cycle: next state EMPTY, the result_i of that cycle is discarded, and no drain is counted.
REQ-023 Held data registers are don't-care while their entry is invalid, but result_o SHALL read 0 after reset.

Reset
REQ-024 Reset SHALL take effect only on a rising clk_i edge with reset_i=1.
REQ-025 On that edge the block SHALL go to state EMPTY and clear the head register, the skid register and the stored flags.
REQ-026 While reset_i=1, the block SHALL ignore valid_i, ready_i and flush_i.
REQ-027 The cycle after reset, the block SHALL drive valid_o=0, ready_o=1, result_o=0, zero_o=0 and negative_o=0.
REQ-028 Reset asserted mid-transfer, including in FULL, SHALL discard all entries, with no output of partial data.
REQ-029 Reset SHALL take priority over flush_i.

Configuration
REQ-030 Macro ALU_RESULT_STAGE_FLAGS_EN SHALL control flag generation.
REQ-031 With ALU_RESULT_STAGE_FLAGS_EN defined, the block SHALL generate, store and drive zero_o and negative_o per REQ-009, REQ-010 and REQ-021.
REQ-032 With ALU_RESULT_STAGE_FLAGS_EN undefined, the block SHALL omit flag storage, tie zero_o and negative_o to 0, leave the ports present and leave all handshake and data behaviour unchanged.

Verification
REQ-033 Single transfer: reset, then result_i=64'h00FF_00FF_00FF_00FF with valid_i=1 for one cycle and ready_i=1 -> the next cycle gives valid_o=1 and that result_o, zero_o=0, negative_o=0; the cycle after gives valid_o=0.
REQ-034 Backpressure: ready_i=0, push 64'h0, then 64'h8000_0000_0000_0000 -> ready_o=0 after the 2nd accept; release ready_i -> outputs come in order, first zero_o=1, then negative_o=1; the 3rd push is not accepted while FULL.
REQ-035 Streaming: valid_i=1 and ready_i=1 for 10 cycles with values 1..10 -> the stage stays in HALF, the outputs are 1..10 at 1-cycle latency, and there are no bubbles.
REQ-036 Flush: in FULL, assert flush_i together with valid_i=1 -> the next cycle gives valid_o=0 and ready_o=1; the flushed-cycle data never appears.
REQ-037 Mid-op reset: in FULL with ready_i=0, assert reset_i for one cycle -> valid_o=0, ready_o=1, result_o=0; a subsequent push of 64'h5 emerges alone.
REQ-038 Macro off: build without ALU_RESULT_STAGE_FLAGS_EN and rerun REQ-034 -> zero_o=0 and negative_o=0 throughout; data order is unchanged.
